// File: rtl/fft_stage_collector_pkg.sv
// Shared types, sizes and index helpers for the FFT column output collector.
package fft_pkg;

    localparam int unsigned CPLX_W     = 64;
    localparam int unsigned N_MACS     = 4;
    localparam int unsigned N_PHASES   = 4;
    localparam int unsigned N_LANES    = 2 * N_MACS;
    localparam int unsigned NPOINT     = N_LANES * N_PHASES;
    localparam int unsigned PH_W       = 2;
    localparam int unsigned IDX_W      = 5;
    localparam int unsigned CNT_W      = 16;
    localparam int unsigned LANE_BUS_W = N_LANES * CPLX_W;
    localparam int unsigned FRAME_W    = NPOINT * CPLX_W;

    // Complex sample: real single in the upper half, imaginary single in the lower.
    typedef struct packed {
        logic [31:0] re;
        logic [31:0] im;
    } cplx_t;

    typedef enum logic [1:0] {
        EMPTY   = 2'd0,
        FILLING = 2'd1,
        FULL    = 2'd2
    } bank_state_e;

    // Frame word written by output h of MAC m during phase p.
    function automatic logic [IDX_W-1:0] idx(input int unsigned m, input int unsigned h,
                                             input logic [PH_W-1:0] p);
        return IDX_W'(m * 2 * N_PHASES + h * N_PHASES + 32'(p));
    endfunction

    function automatic logic [IDX_W-1:0] bitrev5(input logic [IDX_W-1:0] i);
        logic [IDX_W-1:0] r;
        r = '0;
        for (int unsigned b = 0; b < IDX_W; b++) begin
            r[b] = i[IDX_W-1-b];
        end
        return r;
    endfunction

endpackage

// File: rtl/fft_stage_collector_if.sv
// Beat input and frame output bundle of the FFT column collector.
interface fft_stage_collector_if;
    import fft_pkg::*;

    logic                  in_valid;
    logic                  in_ready;
    logic [PH_W-1:0]       in_phase;
    logic [LANE_BUS_W-1:0] in_lane;
    logic                  out_valid;
    logic                  out_ready;
    logic [FRAME_W-1:0]    out_frame;
    logic                  err_seq;
    logic [CNT_W-1:0]      frame_cnt;

    modport master (
        output in_valid, in_phase, in_lane, out_ready,
        input  in_ready, out_valid, out_frame, err_seq, frame_cnt
    );

    modport slave (
        input  in_valid, in_phase, in_lane, out_ready,
        output in_ready, out_valid, out_frame, err_seq, frame_cnt
    );

endinterface

// File: rtl/fft_stage_collector_bank.sv
// One frame buffer: NPOINT complex words, written one phase (all lanes) per beat.
module fft_frame_bank
    import fft_pkg::*;
(
    input  logic                  clk,
    input  logic                  we,
    input  logic [PH_W-1:0]       phase,
    input  logic [LANE_BUS_W-1:0] lanes,
    output logic [FRAME_W-1:0]    words
);

    cplx_t mem [NPOINT];

    // Data storage carries no reset; only the collector's state bits do.
    always_ff @(posedge clk) begin
        if (we) begin
            for (int unsigned m = 0; m < N_MACS; m++) begin
                for (int unsigned h = 0; h < 2; h++) begin
                    mem[idx(m, h, phase)] <= cplx_t'(lanes[(2*m + h)*CPLX_W +: CPLX_W]);
                end
            end
        end
    end

    for (genvar i = 0; i < int'(NPOINT); i++) begin : g_word
        assign words[i*CPLX_W +: CPLX_W] = mem[i];
    end

endmodule

// File: rtl/fft_stage_collector.sv
// Double-buffered collector assembling 4 phases x 8 lanes into 32-point frames.
// FFT_COLLECT_BITREV_EN: present the frame in bit-reversed word order.
module fft_stage_collector
    import fft_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    fft_stage_collector_if.slave  bus
);

    bank_state_e         bank_st   [2];
    bank_state_e         bank_st_n [2];
    logic                wr_bank, wr_bank_n;
    logic                rd_bank, rd_bank_n;
    logic [PH_W-1:0]     exp_phase, exp_phase_n;
    logic                in_ready_q, in_ready_n;
    logic                out_valid_q, out_valid_n;
    logic                err_q, err_n;
    logic [CNT_W-1:0]    cnt_q, cnt_n;
    logic [1:0]          bank_we;
    logic                in_fire;
    logic                out_fire;
    logic [FRAME_W-1:0]  bank_words [2];
    logic [FRAME_W-1:0]  rd_words;

    assign in_fire  = bus.in_valid && in_ready_q;
    assign out_fire = out_valid_q && bus.out_ready;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bank_st[0]  <= EMPTY;
            bank_st[1]  <= EMPTY;
            wr_bank     <= 1'b0;
            rd_bank     <= 1'b0;
            exp_phase   <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            err_q       <= 1'b0;
            cnt_q       <= '0;
        end else begin
            bank_st     <= bank_st_n;
            wr_bank     <= wr_bank_n;
            rd_bank     <= rd_bank_n;
            exp_phase   <= exp_phase_n;
            in_ready_q  <= in_ready_n;
            out_valid_q <= out_valid_n;
            err_q       <= err_n;
            cnt_q       <= cnt_n;
        end
    end

    // Delivery and capture touch different banks, so both can complete on one edge.
    always_comb begin
        bank_st_n   = bank_st;
        wr_bank_n   = wr_bank;
        rd_bank_n   = rd_bank;
        exp_phase_n = exp_phase;
        err_n       = 1'b0;
        cnt_n       = cnt_q;
        bank_we     = '0;

        if (out_fire) begin
            bank_st_n[rd_bank] = EMPTY;
            rd_bank_n          = ~rd_bank;
            cnt_n              = cnt_q + CNT_W'(1);
        end

        if (in_fire) begin
            if (bus.in_phase == exp_phase) begin
                bank_we[wr_bank] = 1'b1;
                if (exp_phase == PH_W'(N_PHASES - 1)) begin
                    bank_st_n[wr_bank] = FULL;
                    exp_phase_n        = '0;
                    wr_bank_n          = ~wr_bank;
                end else begin
                    bank_st_n[wr_bank] = FILLING;
                    exp_phase_n        = exp_phase + PH_W'(1);
                end
            end else begin
                // Out-of-order beat: drop the partial frame, restart only on phase 0.
                err_n = 1'b1;
                if (bus.in_phase == '0) begin
                    bank_we[wr_bank]   = 1'b1;
                    bank_st_n[wr_bank] = FILLING;
                    exp_phase_n        = PH_W'(1);
                end else begin
                    bank_st_n[wr_bank] = EMPTY;
                    exp_phase_n        = '0;
                end
            end
        end

        in_ready_n  = (bank_st_n[wr_bank_n] != FULL);
        out_valid_n = (bank_st_n[rd_bank_n] == FULL);
    end

    for (genvar b = 0; b < 2; b++) begin : g_bank
        fft_frame_bank u_bank (
            .clk   (clk),
            .we    (bank_we[b]),
            .phase (bus.in_phase),
            .lanes (bus.in_lane),
            .words (bank_words[b])
        );
    end

    assign rd_words = bank_words[rd_bank];

    // Output ordering is a fixed wire permutation of the read bank.
    for (genvar i = 0; i < int'(NPOINT); i++) begin : g_out
`ifdef FFT_COLLECT_BITREV_EN
        localparam int unsigned SRC = 32'(bitrev5(IDX_W'(i)));
`else
        localparam int unsigned SRC = i;
`endif
        assign bus.out_frame[i*CPLX_W +: CPLX_W] = rd_words[SRC*CPLX_W +: CPLX_W];
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.err_seq   = err_q;
    assign bus.frame_cnt = cnt_q;

endmodule

// File: doc/fft_stage_collector.md
# fft_stage_collector

Output collector for an FFT butterfly column: accepts the eight time-multiplexed complex MAC results that a column produces each phase and assembles them into a 32-point frame. It is double-buffered, so one frame can be captured while the previous one is held for the next column. Completed frames leave on a parallel bus under a valid/ready handshake. The block sits between a column's MAC array and the next column's input port, replacing open-loop output latching.

## Interface
- CPLX_W, 64, complex word width: [63:32] real IEEE-754 single, [31:0] imag single.
- N_MACS, 4, MAC units per column; lanes = 2*N_MACS.
- N_PHASES, 4, phases per frame; NPOINT = 2*N_MACS*N_PHASES = 32.
- clk  in  1  sole clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- in_valid  in  1  lane beat present.
- in_ready  out  1  collector can accept a beat.
- in_phase  in  2  phase index of the beat (the MAC select value).
- in_lane  in  2*N_MACS*CPLX_W  lane k at bits [k*CPLX_W +: CPLX_W]; k = 2*m + h (MAC m, output h).
- out_valid  out  1  frame available.
- out_ready  in  1  consumer takes the frame.
- out_frame  out  NPOINT*CPLX_W  word i at bits [i*CPLX_W +: CPLX_W].
- err_seq  out  1  one-cycle pulse on a phase-sequence violation.
- frame_cnt  out  16  frames delivered (out handshakes), wraps at 0xFFFF to 0.

## Operation
- A beat transfers on a rising edge when in_valid && in_ready.
- Lane k = 2m+h at phase p writes word index m*8 + h*4 + p.
- Two banks, A and B. Each bank is in one of three states: EMPTY, FILLING, or FULL.
- Write pointer wr_bank and expected phase exp_phase (0..3).
- A transfer with in_phase == exp_phase writes the bank and moves it to FILLING. exp_phase then increments.
- The phase-3 transfer marks the bank FULL, resets exp_phase to 0, and toggles wr_bank.
- A transfer with in_phase != exp_phase:
  - err_seq pulses high for one cycle.
  - The partial frame is discarded (bank returns to EMPTY).
  - If in_phase == 0, the beat is written as phase 0 of a fresh frame and exp_phase becomes 1.
  - Otherwise the beat is dropped and exp_phase becomes 0.
- in_ready = 1 when bank[wr_bank] is not FULL.
- Read pointer rd_bank. out_valid = 1 when bank[rd_bank] is FULL. out_frame reflects bank[rd_bank].
- On an out handshake, bank[rd_bank] becomes EMPTY, rd_bank toggles, and frame_cnt increments.
- Simultaneous phase-3 write to one bank and out handshake on the other bank: both complete on the same edge.
- A frame whose phase-3 beat transfers at edge N is delivered in order ahead of any later frame.
- Bank contents are not cleared on reset or release; only the state bits are.

## Timing
- Reset values:
  - in_ready = 1, out_valid = 0, err_seq = 0, frame_cnt = 0.
  - Both banks EMPTY, wr_bank = rd_bank = A, exp_phase = 0.
  - out_frame is undefined (not reset).
- Latency: the phase-3 transfer at edge N gives out_valid = 1 from edge N.
- Throughput: one beat per cycle sustained when out_ready is held high (4 cycles per frame).
- out_valid and out_frame are stable while out_valid && !out_ready.
- in_ready drops the cycle after both banks are FULL and rises the cycle after the consuming handshake.
- If reset is asserted mid-frame, state returns immediately to reset values and any partial or full frames are lost.

## Configuration
- FFT_COLLECT_BITREV_EN defined: out_frame word i = stored word bitrev5(i). Bit-reversed ordering is done by a combinational permutation with no added latency.
- FFT_COLLECT_BITREV_EN undefined: natural order, out_frame word i = stored word i.

## Structure
- Package fft_pkg:
  - CPLX_W, NPOINT, N_PHASES, N_LANES.
  - bank-state enum {EMPTY, FILLING, FULL}.
  - word-index function idx(m, h, p).
  - bitrev5 function.
- Sub-module fft_frame_bank, instantiated twice:
  - NPOINT x CPLX_W register array.
  - Inputs: we, phase, lanes.
  - Writes the 8 words of the addressed phase.

## Test plan
- Frame ordering: 4 in-order beats, each word's real field = its target index as a float (0.0..31.0), with out_ready = 1 → out_valid after the phase-3 edge; out_frame word 17 = 0x41880000; frame_cnt = 1.
- Backpressure: out_ready = 0 while 8 beats are sent (two frames) → in_ready drops after the 8th transfer and a 9th beat is not accepted. Then out_ready = 1 for 2 cycles → two frames delivered in order, in_ready back to 1.
- Sequence error mid-frame: phases 0, 1, 3 → err_seq pulses on the phase-3 beat, no frame emitted. A following 0, 1, 2, 3 → one frame containing only the new data.
- Sequence error as a new start: phases 0, 1, 0, 1, 2, 3 → one err_seq pulse, one frame whose phase-0 words come from the third beat.
- Reset after 2 beats of a frame → out_valid = 0, in_ready = 1, frame_cnt = 0. A fresh 4-beat frame then delivers correctly.
- FFT_COLLECT_BITREV_EN build: word index = value → out_frame word 1 holds 16.0 and word 3 holds 24.0.
